// File: rtl/axi4l_arb_pkg.sv
// Shared types, state encodings and helpers for the AXI4-Lite round-robin arbiter.
package axi4l_arb_pkg;

    typedef logic [1:0] wr_state_t;
    localparam wr_state_t W_IDLE = 2'd0;
    localparam wr_state_t W_ADDR = 2'd1;
    localparam wr_state_t W_RESP = 2'd2;

    typedef logic [1:0] rd_state_t;
    localparam rd_state_t R_IDLE = 2'd0;
    localparam rd_state_t R_ADDR = 2'd1;
    localparam rd_state_t R_DATA = 2'd2;

    // Index width for n requesters, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 3) ? 1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite channel bundle with master/slave views.
interface axi4l_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
    import axi4l_arb_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_c,
    output logic [IW-1:0] idx_c
);

    // Scan upward from the pointer and take the first set request.
    always_comb begin
        int unsigned   j;
        logic [IW-1:0] jj;
        logic          found;
        grant_c = '0;
        idx_c   = '0;
        found   = 1'b0;
        j       = 0;
        jj      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j  = (32'(ptr) + k) % N;
            jj = IW'(j);
            if (!found && req[jj]) begin
                found       = 1'b1;
                grant_c[jj] = 1'b1;
                idx_c       = jj;
            end
        end
    end

endmodule

// File: rtl/axi4l_arbiter.sv
// Shares one AXI4-Lite slave port among NUM_MASTERS requesters; write and read
// are arbitrated independently with one transaction in flight per path.
module axi4l_arbiter
    import axi4l_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic     aclk,
    input  logic     aresetn,
    axi4l_if.slave   s_axi [NUM_MASTERS],
    axi4l_if.master  m_axi
);

    localparam int unsigned IW = idx_width(NUM_MASTERS);
    localparam int unsigned NP = 1 << IW;
    localparam int unsigned SW = DATA_WIDTH / 8;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;
    logic [IW-1:0] wgrant, wgrant_next, wptr, wptr_next;
    logic [IW-1:0] rgrant, rgrant_next, rptr, rptr_next;
    logic aw_done, aw_done_next, w_done, w_done_next;

    logic [NUM_MASTERS-1:0] aw_req, ar_req, warb_grant, rarb_grant;
    logic [IW-1:0]          warb_idx, rarb_idx;

    logic [ADDR_WIDTH-1:0] awaddr_a [NP];
    logic [ADDR_WIDTH-1:0] araddr_a [NP];
    logic [DATA_WIDTH-1:0] wdata_a  [NP];
    logic [SW-1:0]         wstrb_a  [NP];
    logic [2:0]            awprot_a [NP];
    logic [2:0]            arprot_a [NP];
    logic awvalid_a [NP];
    logic wvalid_a  [NP];
    logic bready_a  [NP];
    logic arvalid_a [NP];
    logic rready_a  [NP];

    logic w_addr, w_resp, r_addr, r_data;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign w_addr = (wr_state == W_ADDR);
    assign w_resp = (wr_state == W_RESP);
    assign r_addr = (rd_state == R_ADDR);
    assign r_data = (rd_state == R_DATA);

    assign aw_hs = m_axi.awvalid && m_axi.awready;
    assign w_hs  = m_axi.wvalid  && m_axi.wready;
    assign b_hs  = m_axi.bvalid  && m_axi.bready;
    assign ar_hs = m_axi.arvalid && m_axi.arready;
    assign r_hs  = m_axi.rvalid  && m_axi.rready;

    rr_arbiter #(.N(NUM_MASTERS)) u_warb (
        .req(aw_req), .ptr(wptr), .grant_c(warb_grant), .idx_c(warb_idx)
    );

    rr_arbiter #(.N(NUM_MASTERS)) u_rarb (
        .req(ar_req), .ptr(rptr), .grant_c(rarb_grant), .idx_c(rarb_idx)
    );

    // Gather upstream requests into indexable arrays and demux responses back.
    for (genvar i = 0; i < NP; i++) begin : g_up
        if (i < NUM_MASTERS) begin : g_port
            localparam logic [IW-1:0] ID = IW'(i);
            logic wsel, rsel;
            assign wsel = (wgrant == ID);
            assign rsel = (rgrant == ID);

            assign aw_req[i]    = s_axi[i].awvalid;
            assign ar_req[i]    = s_axi[i].arvalid;
            assign awaddr_a[i]  = s_axi[i].awaddr;
            assign awprot_a[i]  = s_axi[i].awprot;
            assign awvalid_a[i] = s_axi[i].awvalid;
            assign wdata_a[i]   = s_axi[i].wdata;
            assign wstrb_a[i]   = s_axi[i].wstrb;
            assign wvalid_a[i]  = s_axi[i].wvalid;
            assign bready_a[i]  = s_axi[i].bready;
            assign araddr_a[i]  = s_axi[i].araddr;
            assign arprot_a[i]  = s_axi[i].arprot;
            assign arvalid_a[i] = s_axi[i].arvalid;
            assign rready_a[i]  = s_axi[i].rready;

            assign s_axi[i].awready = w_addr && wsel && !aw_done && m_axi.awready;
            assign s_axi[i].wready  = w_addr && wsel && !w_done  && m_axi.wready;
            assign s_axi[i].bvalid  = w_resp && wsel && m_axi.bvalid;
            assign s_axi[i].bresp   = (w_resp && wsel) ? m_axi.bresp : 2'b00;
            assign s_axi[i].arready = r_addr && rsel && m_axi.arready;
            assign s_axi[i].rvalid  = r_data && rsel && m_axi.rvalid;
            assign s_axi[i].rresp   = (r_data && rsel) ? m_axi.rresp : 2'b00;
            assign s_axi[i].rdata   = (r_data && rsel) ? m_axi.rdata : '0;
        end else begin : g_pad
            assign awaddr_a[i]  = '0;
            assign awprot_a[i]  = '0;
            assign awvalid_a[i] = 1'b0;
            assign wdata_a[i]   = '0;
            assign wstrb_a[i]   = '0;
            assign wvalid_a[i]  = 1'b0;
            assign bready_a[i]  = 1'b0;
            assign araddr_a[i]  = '0;
            assign arprot_a[i]  = '0;
            assign arvalid_a[i] = 1'b0;
            assign rready_a[i]  = 1'b0;
        end
    end

    // Route the granted requester to the shared port; idle paths drive zeros.
    assign m_axi.awaddr  = w_addr ? awaddr_a[wgrant] : '0;
    assign m_axi.awprot  = w_addr ? awprot_a[wgrant] : 3'b000;
    assign m_axi.awvalid = w_addr && !aw_done && awvalid_a[wgrant];
    assign m_axi.wdata   = w_addr ? wdata_a[wgrant] : '0;
    assign m_axi.wstrb   = w_addr ? wstrb_a[wgrant] : '0;
    assign m_axi.wvalid  = w_addr && !w_done && wvalid_a[wgrant];
    assign m_axi.bready  = w_resp && bready_a[wgrant];
    assign m_axi.araddr  = r_addr ? araddr_a[rgrant] : '0;
    assign m_axi.arprot  = r_addr ? arprot_a[rgrant] : 3'b000;
    assign m_axi.arvalid = r_addr && arvalid_a[rgrant];
    assign m_axi.rready  = r_data && rready_a[rgrant];

    // Write path state, grant, pointer and handshake flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state <= W_IDLE;
            wgrant   <= '0;
            wptr     <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            wr_state <= wr_next;
            wgrant   <= wgrant_next;
            wptr     <= wptr_next;
            aw_done  <= aw_done_next;
            w_done   <= w_done_next;
        end
    end

    // Write next-state: grant on AW only, wait for both AW and W, then B.
    always_comb begin
        wr_next      = wr_state;
        wgrant_next  = wgrant;
        wptr_next    = wptr;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        case (wr_state)
            W_IDLE: begin
                if (|warb_grant) begin
                    wgrant_next  = warb_idx;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    wr_next      = W_ADDR;
                end
            end
            W_ADDR: begin
                if (aw_hs) aw_done_next = 1'b1;
                if (w_hs)  w_done_next  = 1'b1;
                if ((aw_done || aw_hs) && (w_done || w_hs)) wr_next = W_RESP;
            end
            W_RESP: begin
                if (b_hs) begin
                    wr_next   = W_IDLE;
                    wptr_next = (wgrant == IW'(NUM_MASTERS - 1)) ? '0 : wgrant + IW'(1);
                end
            end
            default: wr_next = W_IDLE;
        endcase
    end

    // Read path state, grant and pointer.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state <= R_IDLE;
            rgrant   <= '0;
            rptr     <= '0;
        end else begin
            rd_state <= rd_next;
            rgrant   <= rgrant_next;
            rptr     <= rptr_next;
        end
    end

    // Read next-state: grant, AR handshake, R handshake.
    always_comb begin
        rd_next     = rd_state;
        rgrant_next = rgrant;
        rptr_next   = rptr;
        case (rd_state)
            R_IDLE: begin
                if (|rarb_grant) begin
                    rgrant_next = rarb_idx;
                    rd_next     = R_ADDR;
                end
            end
            R_ADDR: if (ar_hs) rd_next = R_DATA;
            R_DATA: begin
                if (r_hs) begin
                    rd_next   = R_IDLE;
                    rptr_next = (rgrant == IW'(NUM_MASTERS - 1)) ? '0 : rgrant + IW'(1);
                end
            end
            default: rd_next = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4l_arbiter.sv
// Directed bench for axi4l_arbiter with three requesters and a simple slave model.
module tb_axi4l_arbiter;
    import axi4l_arb_pkg::*;

    localparam int NM = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4l_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if [NM] ();
    axi4l_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();

    axi4l_arbiter #(.NUM_MASTERS(NM), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .aclk(clk), .aresetn(rst_n), .s_axi(s_if), .m_axi(m_if)
    );

    // Upstream drive and observe arrays
    logic [31:0] up_awaddr [NM];
    logic [31:0] up_wdata  [NM];
    logic [31:0] up_araddr [NM];
    logic        up_awvalid [NM];
    logic        up_wvalid  [NM];
    logic        up_bready  [NM];
    logic        up_arvalid [NM];
    logic        up_rready  [NM];
    logic        up_awready [NM];
    logic        up_wready  [NM];
    logic        up_bvalid  [NM];
    logic [1:0]  up_bresp   [NM];
    logic        up_arready [NM];
    logic        up_rvalid  [NM];
    logic [1:0]  up_rresp   [NM];
    logic [31:0] up_rdata   [NM];

    for (genvar g = 0; g < NM; g++) begin : g_m
        assign s_if[g].awaddr  = up_awaddr[g];
        assign s_if[g].awprot  = 3'(g);
        assign s_if[g].awvalid = up_awvalid[g];
        assign s_if[g].wdata   = up_wdata[g];
        assign s_if[g].wstrb   = 4'hF;
        assign s_if[g].wvalid  = up_wvalid[g];
        assign s_if[g].bready  = up_bready[g];
        assign s_if[g].araddr  = up_araddr[g];
        assign s_if[g].arprot  = 3'(g);
        assign s_if[g].arvalid = up_arvalid[g];
        assign s_if[g].rready  = up_rready[g];
        assign up_awready[g] = s_if[g].awready;
        assign up_wready[g]  = s_if[g].wready;
        assign up_bvalid[g]  = s_if[g].bvalid;
        assign up_bresp[g]   = s_if[g].bresp;
        assign up_arready[g] = s_if[g].arready;
        assign up_rvalid[g]  = s_if[g].rvalid;
        assign up_rresp[g]   = s_if[g].rresp;
        assign up_rdata[g]   = s_if[g].rdata;
    end

    // Slave model: delayed readies, B after AW+W, R = addr ^ A5A50000
    int aw_delay = 0, w_delay = 0;
    int aw_wait, w_wait;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    bit got_aw, got_w;
    int aw_cnt = 0, w_cnt = 0;
    logic [31:0] last_wdata;
    logic [31:0] aw_log [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_if.awready <= 1'b0; m_if.wready <= 1'b0; m_if.bvalid <= 1'b0;
            m_if.bresp <= 2'b00; m_if.arready <= 1'b0; m_if.rvalid <= 1'b0;
            m_if.rdata <= '0; m_if.rresp <= 2'b00;
            aw_wait <= 0; w_wait <= 0; got_aw <= 1'b0; got_w <= 1'b0;
        end else begin
            if (m_if.awvalid && m_if.awready) begin
                m_if.awready <= 1'b0; aw_wait <= 0; got_aw <= 1'b1;
                aw_cnt <= aw_cnt + 1; aw_log.push_back(m_if.awaddr);
            end else if (m_if.awvalid) begin
                if (aw_wait >= aw_delay) m_if.awready <= 1'b1;
                else aw_wait <= aw_wait + 1;
            end
            if (m_if.wvalid && m_if.wready) begin
                m_if.wready <= 1'b0; w_wait <= 0; got_w <= 1'b1;
                w_cnt <= w_cnt + 1; last_wdata <= m_if.wdata;
            end else if (m_if.wvalid) begin
                if (w_wait >= w_delay) m_if.wready <= 1'b1;
                else w_wait <= w_wait + 1;
            end
            if (m_if.bvalid) begin
                if (m_if.bready) m_if.bvalid <= 1'b0;
            end else if (got_aw && got_w) begin
                m_if.bvalid <= 1'b1; m_if.bresp <= bresp_cfg;
                got_aw <= 1'b0; got_w <= 1'b0;
            end
            if (m_if.arvalid && m_if.arready) begin
                m_if.arready <= 1'b0; m_if.rvalid <= 1'b1;
                m_if.rdata <= m_if.araddr ^ 32'hA5A5_0000; m_if.rresp <= rresp_cfg;
            end else if (m_if.arvalid) begin
                m_if.arready <= 1'b1;
            end
            if (m_if.rvalid && m_if.rready) m_if.rvalid <= 1'b0;
        end
    end

    // Monitors for overlap and misrouted responses
    bit mon_en = 1'b0;
    bit overlap_seen = 1'b0;
    int bleak = 0, rleak = 0;
    always @(negedge clk) begin
        if (m_if.awvalid && m_if.arvalid) overlap_seen <= 1'b1;
        if (mon_en && up_bvalid[1]) bleak <= bleak + 1;
        if (mon_en && (up_rvalid[0] || up_rvalid[2])) rleak <= rleak + 1;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] m_out_bits();
        return {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready,
                |m_if.awaddr, |m_if.wdata, |m_if.wstrb, |m_if.araddr,
                |m_if.awprot, |m_if.arprot};
    endfunction

    function automatic logic [7:0] up_out_bits();
        logic [7:0] o;
        o = '0;
        for (int i = 0; i < NM; i++)
            o |= {up_awready[i], up_wready[i], up_bvalid[i], up_arready[i],
                  up_rvalid[i], |up_bresp[i], |up_rresp[i], |up_rdata[i]};
        return o;
    endfunction

    task automatic reset_dut();
        rst_n = 1'b0;
        for (int i = 0; i < NM; i++) begin
            up_awvalid[i] = 0; up_wvalid[i] = 0; up_bready[i] = 0;
            up_arvalid[i] = 0; up_rready[i] = 0;
            up_awaddr[i] = 0; up_wdata[i] = 0; up_araddr[i] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_write(input int m, input logic [31:0] a, input logic [31:0] d,
                            output logic [1:0] resp, output bit ok);
        bit aw_hs, w_hs, b_hs;
        ok = 0; resp = 2'b11;
        up_awaddr[m] = a; up_wdata[m] = d;
        up_awvalid[m] = 1; up_wvalid[m] = 1; up_bready[m] = 1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            aw_hs = up_awvalid[m] && up_awready[m];
            w_hs  = up_wvalid[m] && up_wready[m];
            b_hs  = up_bready[m] && up_bvalid[m];
            if (b_hs) begin resp = up_bresp[m]; ok = 1; end
            @(posedge clk); #1;
            if (aw_hs) up_awvalid[m] = 0;
            if (w_hs)  up_wvalid[m] = 0;
            if (b_hs) begin up_bready[m] = 0; break; end
        end
        @(negedge clk);
    endtask

    task automatic do_read(input int m, input logic [31:0] a,
                           output logic [31:0] data, output logic [1:0] resp, output bit ok);
        bit ar_hs, r_hs;
        ok = 0; resp = 2'b11; data = '0;
        up_araddr[m] = a; up_arvalid[m] = 1; up_rready[m] = 1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            ar_hs = up_arvalid[m] && up_arready[m];
            r_hs  = up_rready[m] && up_rvalid[m];
            if (r_hs) begin data = up_rdata[m]; resp = up_rresp[m]; ok = 1; end
            @(posedge clk); #1;
            if (ar_hs) up_arvalid[m] = 0;
            if (r_hs) begin up_rready[m] = 0; break; end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  r0, r1, r2;
        logic [31:0] d0;
        bit ok0, ok1, ok2;
        int a0, w0;
        logic [31:0] exp_seq [6];

        // Reset state
        rst_n = 1'b0;
        for (int i = 0; i < NM; i++) begin
            up_awvalid[i] = 0; up_wvalid[i] = 0; up_bready[i] = 0;
            up_arvalid[i] = 0; up_rready[i] = 0;
            up_awaddr[i] = 0; up_wdata[i] = 0; up_araddr[i] = 0;
        end
        #1;
        check("reset_m_out", 64'(m_out_bits()), 64'h0);
        check("reset_up_out", 64'(up_out_bits()), 64'h0);
        reset_dut();

        // Single write with delayed readies, plus arbitration latency
        aw_delay = 2; w_delay = 4;
        a0 = aw_cnt; w0 = w_cnt; mon_en = 1;
        fork
            do_write(0, 32'h10, 32'hDEAD_BEEF, r0, ok0);
            begin
                #1 check("lat_same_cycle", 64'(m_if.awvalid), 64'h0);
                @(negedge clk) check("lat_next_cycle", 64'(m_if.awvalid), 64'h1);
            end
        join
        mon_en = 0;
        check("wr1_done", 64'(ok0), 64'h1);
        check("wr1_bresp", 64'(r0), 64'h0);
        check("wr1_aw_count", 64'(aw_cnt - a0), 64'h1);
        check("wr1_w_count", 64'(w_cnt - w0), 64'h1);
        check("wr1_wdata", 64'(last_wdata), 64'hDEAD_BEEF);
        check("wr1_bvalid_m1", 64'(bleak), 64'h0);
        aw_delay = 0; w_delay = 0;

        // Contention: two bursts of three simultaneous writes
        reset_dut();
        aw_log.delete();
        fork
            do_write(0, 32'h0, 32'h100, r0, ok0);
            do_write(1, 32'h4, 32'h101, r1, ok1);
            do_write(2, 32'h8, 32'h102, r2, ok2);
        join
        check("cont1_done", 64'({ok0, ok1, ok2}), 64'h7);
        fork
            do_write(0, 32'h0, 32'h200, r0, ok0);
            do_write(1, 32'h4, 32'h201, r1, ok1);
            do_write(2, 32'h8, 32'h202, r2, ok2);
        join
        check("cont2_done", 64'({ok0, ok1, ok2}), 64'h7);
        exp_seq = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8};
        check("cont_count", 64'(aw_log.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("cont_awaddr%0d", i),
                  (i < aw_log.size()) ? 64'(aw_log[i]) : 64'hFFFF_FFFF, 64'(exp_seq[i]));

        // Concurrent write (m0) and read (m1)
        reset_dut();
        overlap_seen = 0; mon_en = 1;
        fork
            do_write(0, 32'h20, 32'h1234_5678, r0, ok0);
            do_read(1, 32'h24, d0, r1, ok1);
        join
        mon_en = 0;
        check("conc_done", 64'({ok0, ok1}), 64'h3);
        check("conc_overlap", 64'(overlap_seen), 64'h1);
        check("conc_rdata", 64'(d0), 64'hA5A5_0024);
        check("conc_rvalid_other", 64'(rleak), 64'h0);

        // W presented three cycles before AW
        w0 = w_cnt; a0 = aw_cnt;
        up_wdata[1] = 32'h55; up_wvalid[1] = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("wfirst_m_wvalid%0d", i), 64'(m_if.wvalid), 64'h0);
            check($sformatf("wfirst_wready%0d", i), 64'(up_wready[1]), 64'h0);
        end
        do_write(1, 32'h50, 32'h55, r1, ok1);
        check("wfirst_done", 64'(ok1), 64'h1);
        check("wfirst_w_count", 64'(w_cnt - w0), 64'h1);
        check("wfirst_aw_count", 64'(aw_cnt - a0), 64'h1);

        // Read response passthrough
        rresp_cfg = 2'b10;
        do_read(2, 32'h40, d0, r2, ok2);
        rresp_cfg = 2'b00;
        check("rresp_done", 64'(ok2), 64'h1);
        check("rresp_value", 64'(r2), 64'h2);
        check("rresp_rdata", 64'(d0), 64'hA5A5_0040);

        // Reset while B is pending
        up_awaddr[0] = 32'h30; up_wdata[0] = 32'h77;
        up_awvalid[0] = 1; up_wvalid[0] = 1; up_bready[0] = 0;
        for (int c = 0; c < 50 && !up_bvalid[0]; c++) @(negedge clk);
        check("rst_pre_bvalid", 64'(up_bvalid[0]), 64'h1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_m_out", 64'(m_out_bits()), 64'h0);
        check("rst_mid_up_out", 64'(up_out_bits()), 64'h0);
        reset_dut();
        fork
            do_write(1, 32'h60, 32'h66, r1, ok1);
            @(negedge clk) check("rst_after_awaddr", 64'(m_if.awaddr), 64'h60);
        join
        check("rst_after_done", 64'(ok1), 64'h1);
        check("rst_after_bresp", 64'(r1), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
